// File: rtl/qam_carrier_sched.sv
// qam_carrier_sched: sequences I/Q symbols into the cosine/sine carrier
// multipliers. Each accepted symbol is held for sps samples while a phase
// index walks the 16-step carrier period. A lat-deep delay line lines the
// sample-valid strobe up with the multiplier outputs.
module qam_carrier_sched #(
  parameter int width_sym = 16,
  parameter int width_sel = 4,
  parameter int sps       = 16,
  parameter int lat       = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [width_sym-1:0] sym_i,
  input  logic [width_sym-1:0] sym_q,
  input  logic                 sym_valid,
  output logic                 sym_ready,
  output logic [width_sym-1:0] mul_data_i,
  output logic [width_sym-1:0] mul_data_q,
  output logic [width_sel-1:0] mul_sel_cos,
  output logic [width_sel-1:0] mul_sel_sin,
  output logic                 mul_start,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 underrun
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

  localparam int DW = (lat > 1) ? $clog2(lat) : 1;
  localparam logic [7:0]           SC_LAST = 8'(sps - 1);
  localparam logic [DW-1:0]        DR_LAST = DW'(lat - 1);
  // A quarter period behind cosine gives sine: (k + 3/4 period) mod period.
  localparam logic [width_sel-1:0] SIN_OFS = width_sel'((3 * (1 << width_sel)) / 4);

  state_t               state_q, state_d;
  logic [width_sel-1:0] ph_q, ph_d;
  logic [7:0]           sc_q, sc_d;
  logic [DW-1:0]        dr_q, dr_d;
  logic [width_sym-1:0] data_i_q, data_i_d;
  logic [width_sym-1:0] data_q_q, data_q_d;
  logic                 start_q, start_d;
  logic                 und_q, und_d;
  logic [lat-1:0]       dl_q, dl_d;
  logic                 accept;

  // Ready depends only on registered state and the live enable request.
  assign sym_ready = enable & ((state_q == ST_IDLE) |
                               ((state_q == ST_RUN) & (sc_q == SC_LAST)));
  assign accept    = sym_valid & sym_ready;

  // Next-state logic for the IDLE/RUN/DRAIN sequencer and its counters.
  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    sc_d     = sc_q;
    dr_d     = dr_q;
    data_i_d = data_i_q;
    data_q_d = data_q_q;
    start_d  = start_q;
    und_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_RUN;
          ph_d     = '0;
          sc_d     = '0;
          start_d  = 1'b1;
          data_i_d = sym_i;
          data_q_d = sym_q;
        end
      end
      ST_RUN: begin
        // Phase keeps running across symbol boundaries (phase-continuous).
        ph_d = ph_q + width_sel'(1);
        sc_d = sc_q + 8'd1;
        if (sc_q == SC_LAST) begin
          if (accept) begin
            sc_d     = '0;
            data_i_d = sym_i;
            data_q_d = sym_q;
          end else begin
            // Feed zeros for lat cycles so the multiplier pipeline empties.
            state_d  = ST_DRAIN;
            dr_d     = '0;
            data_i_d = '0;
            data_q_d = '0;
            und_d    = enable;
          end
        end
      end
      ST_DRAIN: begin
        ph_d = ph_q + width_sel'(1);
        dr_d = dr_q + DW'(1);
        if (dr_q == DR_LAST) begin
          state_d = ST_IDLE;
          start_d = 1'b0;
          ph_d    = '0;
          sc_d    = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Delay line for the data-bearing flag: bit 0 is the current RUN flag.
  assign dl_d[0] = (state_q == ST_RUN);
  for (genvar gi = 1; gi < lat; gi++) begin : g_dl
    assign dl_d[gi] = dl_q[gi-1];
  end

  // State and datapath registers; reset discards any in-flight samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ph_q     <= '0;
      sc_q     <= '0;
      dr_q     <= '0;
      data_i_q <= '0;
      data_q_q <= '0;
      start_q  <= 1'b0;
      und_q    <= 1'b0;
      dl_q     <= '0;
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      sc_q     <= sc_d;
      dr_q     <= dr_d;
      data_i_q <= data_i_d;
      data_q_q <= data_q_d;
      start_q  <= start_d;
      und_q    <= und_d;
      dl_q     <= dl_d;
    end
  end

  assign mul_data_i  = data_i_q;
  assign mul_data_q  = data_q_q;
  assign mul_sel_cos = ph_q;
  assign mul_sel_sin = ph_q + SIN_OFS;
  assign mul_start   = start_q;
  assign out_valid   = dl_q[lat-1];
  assign busy        = (state_q != ST_IDLE) | (|dl_q);
  assign underrun    = und_q;

endmodule

// File: tb/tb_qam_carrier_sched.sv
// Bench for qam_carrier_sched: a sps=16 instance (a_*) exercised by
// hand-written multi-cycle sequences, and a sps=1 instance (b_*) exercised
// by a vector table. Inputs are shared; outputs are checked at negedge.
module tb_qam_carrier_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        sym_valid = 1'b0;
  logic [15:0] sym_i = '0;
  logic [15:0] sym_q = '0;

  logic        a_rdy, a_start, a_ov, a_busy, a_und;
  logic [15:0] a_di, a_dq;
  logic [3:0]  a_cos, a_sin;
  logic        b_rdy, b_start, b_ov, b_busy, b_und;
  logic [15:0] b_di, b_dq;
  logic [3:0]  b_cos, b_sin;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  qam_carrier_sched #(.width_sym(16), .width_sel(4), .sps(16), .lat(2)) u_a (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .sym_i(sym_i), .sym_q(sym_q), .sym_valid(sym_valid), .sym_ready(a_rdy),
    .mul_data_i(a_di), .mul_data_q(a_dq), .mul_sel_cos(a_cos), .mul_sel_sin(a_sin),
    .mul_start(a_start), .out_valid(a_ov), .busy(a_busy), .underrun(a_und)
  );

  qam_carrier_sched #(.width_sym(16), .width_sel(4), .sps(1), .lat(2)) u_b (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .sym_i(sym_i), .sym_q(sym_q), .sym_valid(sym_valid), .sym_ready(b_rdy),
    .mul_data_i(b_di), .mul_data_q(b_dq), .mul_sel_cos(b_cos), .mul_sel_sin(b_sin),
    .mul_start(b_start), .out_valid(b_ov), .busy(b_busy), .underrun(b_und)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Registered outputs of the sps=16 instance.
  task automatic check_a(input string tag, input logic st, input logic [3:0] ph,
                         input logic [15:0] di, input logic [15:0] dq,
                         input logic ov, input logic bz, input logic un);
    logic [3:0] sn;
    sn = ph + 4'd12;
    chk({tag, " start"}, a_start, st);
    chk({tag, " sel_cos"}, a_cos, ph);
    chk({tag, " sel_sin"}, a_sin, sn);
    chk({tag, " data_i"}, a_di, di);
    chk({tag, " data_q"}, a_dq, dq);
    chk({tag, " out_valid"}, a_ov, ov);
    chk({tag, " busy"}, a_busy, bz);
    chk({tag, " underrun"}, a_und, un);
  endtask

  function automatic logic [15:0] vi(input int n);
    return 16'(32'h1000 + n * 32'h0100);
  endfunction

  function automatic logic [15:0] vq(input int n);
    return 16'(32'hF000 - n * 32'h0100);
  endfunction

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0; enable = 1'b1; sym_valid = 1'b0; sym_i = '0; sym_q = '0;
    #1;
    check_a({tag, " in-reset"}, 0, 4'd0, 16'h0, 16'h0, 0, 0, 0);
    chk({tag, " in-reset ready"}, a_rdy, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_a($sformatf("%s post-reset c%0d", tag, k), 0, 4'd0, 16'h0, 16'h0, 0, 0, 0);
      chk($sformatf("%s post-reset c%0d ready", tag, k), a_rdy, 1);
    end
  endtask

  // n symbols on the sps=16 instance starting from IDLE. Cycle k=0 is the
  // accept cycle; cycle k holds the state after k rising edges.
  task automatic run_seq(input string tag, input int n, input bit drop);
    int   last;
    int   ovcnt;
    bit   run, drn, en_k, en_bnd;
    logic [3:0]  ph;
    logic [15:0] di, dq;
    string t;
    last  = 16 * n;
    ovcnt = 0;
    en_bnd = 1'b1;
    @(negedge clk);
    enable = 1'b1; sym_valid = 1'b1; sym_i = vi(0); sym_q = vq(0);
    #1 chk({tag, " k0 ready"}, a_rdy, 1);
    for (int k = 1; k <= last + 4; k++) begin
      @(negedge clk);
      t   = $sformatf("%s k%0d", tag, k);
      run = (k <= last);
      drn = (k > last) && (k <= last + 2);
      ph  = (run || drn) ? 4'((k - 1) % 16) : 4'd0;
      di  = run ? vi((k - 1) / 16) : 16'h0;
      dq  = run ? vq((k - 1) / 16) : 16'h0;
      check_a(t, k <= last + 2, ph, di, dq, (k >= 3) && (k <= last + 2),
              k <= last + 2, (k == last + 1) && en_bnd);
      if (a_ov) ovcnt++;
      en_k = !(drop && k >= 6);
      if (k == last) en_bnd = en_k;
      enable    = en_k;
      sym_valid = drop ? 1'b1 : (k <= 16 * (n - 1));
      sym_i     = vi(k / 16);
      sym_q     = vq(k / 16);
      #1 chk({t, " ready"}, a_rdy, en_k && ((run && ((k - 1) % 16 == 15)) || (k > last + 2)));
    end
    chk({tag, " out_valid count"}, ovcnt, last);
    enable = 1'b1; sym_valid = 1'b0;
  endtask

  typedef struct {
    logic        en;
    logic        vld;
    logic [15:0] d;
    logic        rdy;
    logic        st;
    logic [3:0]  ph;
    logic [15:0] data;
    logic        ov;
    logic        bz;
    logic        un;
  } vec_t;

  vec_t tbl[10];

  initial begin
    // sps=1: four back-to-back symbols, then a 2-cycle drain.
    tbl[0] = '{1, 1, 16'd1, 1, 0, 4'd0, 16'd0, 0, 0, 0};
    tbl[1] = '{1, 1, 16'd2, 1, 1, 4'd0, 16'd1, 0, 1, 0};
    tbl[2] = '{1, 1, 16'd3, 1, 1, 4'd1, 16'd2, 0, 1, 0};
    tbl[3] = '{1, 1, 16'd4, 1, 1, 4'd2, 16'd3, 1, 1, 0};
    tbl[4] = '{1, 0, 16'd0, 1, 1, 4'd3, 16'd4, 1, 1, 0};
    tbl[5] = '{1, 0, 16'd0, 0, 1, 4'd4, 16'd0, 1, 1, 1};
    tbl[6] = '{1, 0, 16'd0, 0, 1, 4'd5, 16'd0, 1, 1, 0};
    tbl[7] = '{1, 0, 16'd0, 1, 0, 4'd0, 16'd0, 0, 0, 0};
    tbl[8] = '{0, 1, 16'd9, 0, 0, 4'd0, 16'd0, 0, 0, 0};
    tbl[9] = '{1, 0, 16'd0, 1, 0, 4'd0, 16'd0, 0, 0, 0};

    do_reset("rst0");

    for (int r = 0; r < 10; r++) begin
      logic [3:0]  sn;
      logic [15:0] nq;
      string t;
      @(negedge clk);
      t  = $sformatf("sps1 row%0d", r);
      sn = tbl[r].ph + 4'd12;
      nq = -tbl[r].data;
      chk({t, " start"}, b_start, tbl[r].st);
      chk({t, " sel_cos"}, b_cos, tbl[r].ph);
      chk({t, " sel_sin"}, b_sin, sn);
      chk({t, " data_i"}, b_di, tbl[r].data);
      chk({t, " data_q"}, b_dq, nq);
      chk({t, " out_valid"}, b_ov, tbl[r].ov);
      chk({t, " busy"}, b_busy, tbl[r].bz);
      chk({t, " underrun"}, b_und, tbl[r].un);
      enable = tbl[r].en; sym_valid = tbl[r].vld;
      sym_i = tbl[r].d; sym_q = -tbl[r].d;
      #1 chk({t, " ready"}, b_rdy, tbl[r].rdy);
    end

    do_reset("rst1");
    run_seq("single", 1, 1'b0);
    run_seq("three", 3, 1'b0);
    run_seq("endrop", 1, 1'b1);

    // Reset asserted at sample 7 of a symbol.
    @(negedge clk);
    enable = 1'b1; sym_valid = 1'b1; sym_i = 16'h1234; sym_q = 16'h4321;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      sym_valid = 1'b0;
      chk($sformatf("midrst k%0d sel_cos", k), a_cos, 4'(k - 1));
      chk($sformatf("midrst k%0d data_i", k), a_di, 16'h1234);
    end
    rst_n = 1'b0;
    #1;
    check_a("midrst asserted", 0, 4'd0, 16'h0, 16'h0, 0, 0, 0);
    chk("midrst asserted ready", a_rdy, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_a($sformatf("midrst after c%0d", k), 0, 4'd0, 16'h0, 16'h0, 0, 0, 0);
    end
    run_seq("postrst", 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/qam_carrier_sched.md
# qam_carrier_sched

Sequencer for the transmitter's cosine/sine carrier multipliers. It accepts I/Q symbol pairs over a valid/ready handshake and holds each symbol for `sps` samples. For every sample it drives the 4-bit phase index to both carrier multipliers (16 phase steps per carrier period) and issues the multiplier `start`. It also produces a sample-valid strobe aligned with the multipliers' pipelined outputs, so downstream summing logic can form the QAM-16 sample.

## Interface
- `width_sym`, 16, symbol and sample width (signed two's complement)
- `width_sel`, 4, phase-index width; carrier period is 2^width_sel = 16 samples
- `sps`, 16, samples per symbol, legal range 1..255
- `lat`, 2, multiplier pipeline latency in cycles from `start`/`sel`/data to `data_out`
- `clk`  in  1  clock; all logic on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `enable`  in  1  run request; 0 = finish current symbol, then stop
- `sym_i`  in  width_sym  signed in-phase amplitude
- `sym_q`  in  width_sym  signed quadrature amplitude
- `sym_valid`  in  1  symbol pair available
- `sym_ready`  out  1  block accepts the pair this cycle
- `mul_data_i`  out  width_sym  data to cosine multiplier
- `mul_data_q`  out  width_sym  data to sine multiplier
- `mul_sel_cos`  out  width_sel  cosine phase index
- `mul_sel_sin`  out  width_sel  sine phase index, always (`mul_sel_cos` + 12) mod 16
- `mul_start`  out  1  multiplier start/advance
- `out_valid`  out  1  multiplier outputs carry a data-bearing sample this cycle
- `busy`  out  1  state ≠ IDLE or samples still in flight
- `underrun`  out  1  one-cycle pulse: symbol boundary reached with `enable`=1 and no symbol

## Operation
- The multiplier phase index k selects the carrier value cos(2πk/16). Index (k+12) mod 16 gives sin(2πk/16).
- The block has three states: IDLE, RUN and DRAIN. It keeps a phase counter `ph` (width_sel), a sample counter `sc` (8 bits) and a drain counter.
- `sym_ready` is combinational from registered state and `enable`:
  - It is 1 when state=IDLE and `enable`=1.
  - It is 1 when state=RUN, `sc`=sps-1 and `enable`=1.
  - It is 0 otherwise, including during DRAIN.
- Accept = `sym_valid` & `sym_ready`. On accept, `sym_i`/`sym_q` register into `mul_data_i`/`mul_data_q` and `sc`←0.
- IDLE → RUN on accept:
  - `ph`←0.
  - `mul_start`←1.
- RUN: each cycle `ph`←`ph`+1 mod 16 and `sc`←`sc`+1.
  - At `sc`=sps-1 with accept: load the new symbol, `sc`←0, and `ph` continues incrementing (phase-continuous across symbols). The stay in RUN is gap-free.
  - At `sc`=sps-1 without accept: go to DRAIN. Data registers ←0, `mul_start` stays 1 and `ph` keeps incrementing.
  - `underrun` pulses in the cycle after this transition if `enable` was 1 at the boundary.
- DRAIN: lasts exactly `lat` cycles with zero data, to flush the multiplier pipeline. Then go to IDLE with `mul_start`←0, `ph`←0 and `sc`←0.
  - Accept is not possible in DRAIN. A new symbol waits for IDLE.
- `out_valid` is the `lat`-cycle delay of the per-cycle "data-bearing sample" flag. The flag is 1 in RUN and 0 in DRAIN and IDLE.
- `busy` = (state≠IDLE) | any bit of the `out_valid` delay line.
- Deasserting `enable` mid-symbol has no effect until the symbol boundary; the symbol completes all `sps` samples.
- `sym_valid` without `sym_ready` is ignored; the block never drops an accepted symbol.

## Timing
- Reset values:
  - state=IDLE.
  - `sym_ready` follows its combinational equation, so it is 1 if `enable`=1.
  - `mul_data_i`, `mul_data_q`, `mul_sel_cos` = 0.
  - `mul_sel_sin` = 12.
  - `mul_start`, `out_valid`, `busy`, `underrun` = 0.
  - All delay lines are cleared.
- If `rst_n` asserts mid-operation, everything returns to reset values at once. The in-flight symbol and its samples are discarded and no `out_valid` is issued for them.
- Accept at edge T: `mul_start`=1 with `mul_sel_cos`=0 during cycle T+1. The first `out_valid`=1 occurs in cycle T+1+`lat`.
- One symbol produces exactly `sps` consecutive `out_valid` cycles.
- Back-to-back symbols produce a continuous `out_valid` with no bubble.
- Drain: the last data sample is at cycle D. Zero-data samples run from D+1 to D+`lat`, and `mul_start`=0 from D+`lat`+1. `busy` falls once the last `out_valid` has been issued.
- `sps`=1: `sym_ready` can be 1 every RUN cycle, giving one symbol per clock.

## Test plan
- Reset with `enable`=1, `sym_valid`=0:
  - Outputs hold reset values and `sym_ready`=1.
  - After `rst_n` rises, nothing changes until `sym_valid`.
- Single symbol I=0x1000, Q=0xF000, `sps`=16:
  - Exactly 16 `out_valid` cycles, starting 3 cycles after accept.
  - `mul_sel_cos` runs 0..15 and `mul_sel_sin` runs 12,13,14,15,0..11.
  - Then 2 drain cycles with data 0, `underrun` pulses once, and `busy`→0.
- Three symbols held valid continuously: 48 contiguous `out_valid` cycles.
  - Phase is continuous: the second symbol starts at `mul_sel_cos`=0 after wrapping 15→0, with no reset.
  - `sym_ready` pulses exactly at `sc`=15.
- `enable` dropped at sample 5 of a symbol: remaining samples 6..15 are still issued, with no `underrun` and no further accept; the block then returns to IDLE.
- `rst_n` asserted at sample 7: all outputs return to reset values in the same cycle and no further `out_valid` appears. After release, a new symbol starts at `mul_sel_cos`=0.
- `sps`=1, symbols 1,2,3,4 back-to-back: `mul_data_i` changes every cycle, `sym_ready` stays high, and `out_valid` runs 4 cycles followed by a 2-cycle drain.
